// File: rtl/syncfifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO.
// Holds the default geometry, the derived default sizes and a constant
// ceil-log2 helper used to size RAM address ports.
package syncfifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_AW    = 12;
  localparam int DEPTH_N   = 1 << DEF_AW;
  localparam int CNTW      = DEF_AW + 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/syncfifo_ram.sv
// Simple dual-port storage for the FIFO: one write port and one registered
// read port. Same-address write and read in one cycle returns the old word.
// Ports:
//   clk          clock
//   we/waddr/wd  write enable, address, data
//   re/raddr     read enable and address; q loads mem[raddr] when re=1
//   clr_q        synchronous clear of the read register (wins over re)
//   q            registered read data
module syncfifo_ram
  import syncfifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEPTH_N
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [clog2(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]          wd,
  input  logic                      re,
  input  logic [clog2(DEPTH)-1:0]   raddr,
  input  logic                      clr_q,
  output logic [WIDTH-1:0]          q
);

  (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wd;
  end

  // Output register clear maps onto the block-RAM output latch reset.
  always_ff @(posedge clk) begin
    if (clr_q)   q <= '0;
    else if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/syncfifo_param.sv
// Parametrised synchronous FIFO with programmable almost-full/almost-empty
// thresholds, optional first-word-fall-through read, flush and sticky
// overflow/underflow flags.
// Ports:
//   clk, rst_n (sync, active-low), clr (sync flush)
//   wd/we write side, ful/aful full and almost-full
//   rd/re read side, emp/aemp empty and almost-empty
//   afull_th/aempty_th thresholds, cnt words held, ovf/udf sticky errors
module syncfifo_param
  import syncfifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_AW,
  parameter bit FWFT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [WIDTH-1:0] wd,
  input  logic             we,
  output logic             ful,
  output logic             aful,
  output logic [WIDTH-1:0] rd,
  input  logic             re,
  output logic             emp,
  output logic             aemp,
  input  logic [AW:0]      afull_th,
  input  logic [AW:0]      aempty_th,
  output logic [AW:0]      cnt,
  output logic             ovf,
  output logic             udf
);

  localparam int DEPTH = 1 << AW;
  localparam int CW    = AW + 1;

  logic [AW-1:0] wptr, rptr;
  logic          wa, ra;
  logic          ram_we, ram_re, ram_clr;
  logic          emp_next;
  logic [CW-1:0] cnt_next;

  assign wa       = we & ~ful;
  assign ra       = re & ~emp;
  assign cnt_next = cnt + CW'(wa) - CW'(ra);
  assign ram_we   = wa & rst_n & ~clr;
  assign ram_clr  = ~rst_n | clr;

  // The RAM read register doubles as rd in both modes.
  syncfifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wptr),
    .wd    (wd),
    .re    (ram_re),
    .raddr (rptr),
    .clr_q (ram_clr),
    .q     (rd)
  );

  if (FWFT) begin : g_fwft
    // valid marks rd as holding the head word; memory holds cnt - valid words.
    logic valid;
    logic mem_avail;

    assign mem_avail = (cnt != CW'(valid));
    // Refill the output register whenever it is empty or being popped.
    assign ram_re    = mem_avail & (~valid | ra);
    assign emp_next  = ~(ram_re | (valid & ~ra));

    always_ff @(posedge clk) begin
      if (!rst_n || clr) valid <= 1'b0;
      else if (ram_re)   valid <= 1'b1;
      else if (ra)       valid <= 1'b0;
    end
  end else begin : g_std
    assign ram_re   = ra;
    assign emp_next = (cnt_next == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      ful  <= 1'b0;
      aful <= 1'b0;
      emp  <= 1'b1;
      aemp <= 1'b1;
      ovf  <= 1'b0;
      udf  <= 1'b0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      ful  <= 1'b0;
      aful <= 1'b0;
      emp  <= 1'b1;
      aemp <= 1'b1;
    end else begin
      if (wa)     wptr <= wptr + AW'(1);
      if (ram_re) rptr <= rptr + AW'(1);
      cnt  <= cnt_next;
      ful  <= (cnt_next == CW'(DEPTH));
      emp  <= emp_next;
      aful <= (cnt_next >= afull_th);
      aemp <= (cnt_next <= aempty_th);
      if (we & ful) ovf <= 1'b1;
      if (re & emp) udf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_syncfifo_param.sv
module tb_syncfifo_param;

  localparam int W = 8;
  localparam int A = 4;
  localparam int D = 1 << A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, clr;
  logic [A:0]   afull_th, aempty_th;
  logic [W-1:0] wd, f_wd;
  logic         we, re, f_we, f_re;

  logic         ful, aful, emp, aemp, ovf, udf;
  logic [W-1:0] rd;
  logic [A:0]   cnt;
  logic         f_ful, f_aful, f_emp, f_aemp, f_ovf, f_udf;
  logic [W-1:0] f_rd;
  logic [A:0]   f_cnt;

  syncfifo_param #(.WIDTH(W), .AW(A), .FWFT(1'b0)) u_std (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wd(wd), .we(we), .ful(ful),
    .aful(aful), .rd(rd), .re(re), .emp(emp), .aemp(aemp),
    .afull_th(afull_th), .aempty_th(aempty_th), .cnt(cnt), .ovf(ovf), .udf(udf)
  );

  syncfifo_param #(.WIDTH(W), .AW(A), .FWFT(1'b1)) u_fw (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wd(f_wd), .we(f_we), .ful(f_ful),
    .aful(f_aful), .rd(f_rd), .re(f_re), .emp(f_emp), .aemp(f_aemp),
    .afull_th(afull_th), .aempty_th(aempty_th), .cnt(f_cnt), .ovf(f_ovf), .udf(f_udf)
  );

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: queues of stored words, updated at each rising edge
  // from the inputs the DUTs see at that edge.
  logic [W-1:0] sq[$];
  logic [W-1:0] fq[$];
  logic [W-1:0] m_rd, mf_rd;
  logic m_ovf, m_udf, m_aful, m_aemp;
  logic mf_ovf, mf_udf, mf_aful, mf_aemp, mf_vis;

  always @(posedge clk) begin : model
    bit dw, dr;
    if (!rst_n) begin
      sq.delete(); fq.delete();
      m_rd = '0; mf_rd = '0; mf_vis = 1'b0;
      m_ovf = 1'b0; m_udf = 1'b0; mf_ovf = 1'b0; mf_udf = 1'b0;
      m_aful = 1'b0; m_aemp = 1'b1; mf_aful = 1'b0; mf_aemp = 1'b1;
    end else if (clr) begin
      sq.delete(); fq.delete();
      m_rd = '0; mf_rd = '0; mf_vis = 1'b0;
      m_aful = 1'b0; m_aemp = 1'b1; mf_aful = 1'b0; mf_aemp = 1'b1;
    end else begin
      // standard-mode FIFO
      dw = we && (sq.size() < D);
      dr = re && (sq.size() > 0);
      if (we && sq.size() == D) m_ovf = 1'b1;
      if (re && sq.size() == 0) m_udf = 1'b1;
      if (dr) m_rd = sq.pop_front();
      if (dw) sq.push_back(wd);
      m_aful = (sq.size() >= int'(afull_th));
      m_aemp = (sq.size() <= int'(aempty_th));
      // FWFT FIFO: a word is readable only once shown on rd; a word written
      // at this edge cannot be shown before the next one.
      dw = f_we && (fq.size() < D);
      dr = f_re && mf_vis;
      if (f_we && fq.size() == D) mf_ovf = 1'b1;
      if (f_re && !mf_vis) mf_udf = 1'b1;
      if (dr) void'(fq.pop_front());
      if ((!mf_vis || dr) && fq.size() > 0) begin
        mf_vis = 1'b1;
        mf_rd  = fq[0];
      end else if (dr) begin
        mf_vis = 1'b0;
      end
      if (dw) fq.push_back(f_wd);
      mf_aful = (fq.size() >= int'(afull_th));
      mf_aemp = (fq.size() <= int'(aempty_th));
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("std_cnt",  cnt,  sq.size());
      chk("std_ful",  ful,  sq.size() == D);
      chk("std_emp",  emp,  sq.size() == 0);
      chk("std_aful", aful, m_aful);
      chk("std_aemp", aemp, m_aemp);
      chk("std_ovf",  ovf,  m_ovf);
      chk("std_udf",  udf,  m_udf);
      chk("std_rd",   rd,   m_rd);
      chk("fw_cnt",   f_cnt,  fq.size());
      chk("fw_ful",   f_ful,  fq.size() == D);
      chk("fw_emp",   f_emp,  !mf_vis);
      chk("fw_aful",  f_aful, mf_aful);
      chk("fw_aemp",  f_aemp, mf_aemp);
      chk("fw_ovf",   f_ovf,  mf_ovf);
      chk("fw_udf",   f_udf,  mf_udf);
      chk("fw_rd",    f_rd,   mf_rd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; we = 1'b0; re = 1'b0; wd = '0;
    f_we = 1'b0; f_re = 1'b0; f_wd = '0;
    afull_th = 5'd14; aempty_th = 5'd2;
    tick();
    chk_en = 1'b1;
    tick();
    rst_n = 1'b1;

    // reset values
    chk("rst_cnt", cnt, 0);   chk("rst_emp", emp, 1);  chk("rst_aemp", aemp, 1);
    chk("rst_ful", ful, 0);   chk("rst_aful", aful, 0); chk("rst_rd", rd, 0);
    chk("rst_ovf", ovf, 0);   chk("rst_udf", udf, 0);  chk("rst_fw_emp", f_emp, 1);

    // 1: fill, overflow, drain in order
    for (int i = 0; i < 16; i++) begin
      we = 1'b1; wd = 8'(i);
      tick();
      if (i == 12) chk("t1_aful_at13", aful, 0);
      if (i == 13) chk("t1_aful_at14", aful, 1);
      if (i == 14) chk("t1_ful_at15", ful, 0);
    end
    chk("t1_ful", ful, 1);
    chk("t1_cnt16", cnt, 16);
    wd = 8'h77;
    tick();
    we = 1'b0;
    chk("t1_ovf", ovf, 1);
    chk("t1_cnt_ovf", cnt, 16);
    for (int i = 0; i < 16; i++) begin
      re = 1'b1;
      tick();
      chk("t1_rd_order", rd, i);
    end
    re = 1'b0;
    chk("t1_emp", emp, 1);

    // 2: underflow, simultaneous we&re on empty
    re = 1'b1;
    tick();
    re = 1'b0;
    chk("t2_udf", udf, 1);
    chk("t2_cnt0", cnt, 0);
    chk("t2_rd_hold", rd, 8'h0F);
    we = 1'b1; re = 1'b1; wd = 8'h3C;
    tick();
    we = 1'b0; re = 1'b0;
    chk("t2_cnt1", cnt, 1);
    chk("t2_emp0", emp, 0);
    chk("t2_rd_hold2", rd, 8'h0F);

    // 3: we&re at full, then steady streaming with wrap
    for (int i = 0; i < 15; i++) begin
      we = 1'b1; wd = 8'(8'h40 + i);
      tick();
    end
    chk("t3_full", ful, 1);
    we = 1'b1; re = 1'b1; wd = 8'hAA;
    tick();
    we = 1'b0; re = 1'b0;
    chk("t3_cnt15", cnt, 15);
    chk("t3_rd_oldest", rd, 8'h3C);
    chk("t3_ovf_held", ovf, 1);
    for (int i = 0; i < 10; i++) begin
      re = 1'b1;
      tick();
    end
    re = 1'b0;
    chk("t3_cnt5", cnt, 5);
    chk("t3_rd49", rd, 8'h49);
    for (int k = 0; k < 40; k++) begin
      we = 1'b1; re = 1'b1; wd = 8'(8'h80 + k);
      tick();
    end
    we = 1'b0; re = 1'b0;
    chk("t3_stream_cnt", cnt, 5);
    chk("t3_stream_rd", rd, 8'hA2);
    for (int k = 0; k < 5; k++) begin
      re = 1'b1;
      tick();
      chk("t3_drain_rd", rd, 8'hA3 + k);
    end
    re = 1'b0;
    chk("t3_emp", emp, 1);

    // 5: flush with concurrent write, then reset mid-operation
    for (int i = 0; i < 9; i++) begin
      we = 1'b1; wd = 8'(8'h10 + i);
      tick();
    end
    chk("t5_cnt9", cnt, 9);
    clr = 1'b1; wd = 8'hEE;
    tick();
    clr = 1'b0; we = 1'b0;
    chk("t5_clr_cnt", cnt, 0);  chk("t5_clr_emp", emp, 1); chk("t5_clr_aemp", aemp, 1);
    chk("t5_clr_ful", ful, 0);  chk("t5_clr_ovf", ovf, 1); chk("t5_clr_udf", udf, 1);
    chk("t5_clr_rd", rd, 0);
    tick();
    chk("t5_clr_discard", cnt, 0);
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; wd = 8'(8'h20 + i);
      tick();
    end
    we = 1'b0; re = 1'b1;
    tick();
    re = 1'b0;
    chk("t5_cnt7", cnt, 7);
    chk("t5_rd20", rd, 8'h20);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5_rst_cnt", cnt, 0);  chk("t5_rst_emp", emp, 1); chk("t5_rst_aemp", aemp, 1);
    chk("t5_rst_ful", ful, 0);  chk("t5_rst_aful", aful, 0); chk("t5_rst_ovf", ovf, 0);
    chk("t5_rst_udf", udf, 0);  chk("t5_rst_rd", rd, 0);

    // 6: runtime threshold changes
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; wd = 8'(8'h30 + i);
      tick();
    end
    we = 1'b0;
    chk("t6_aful_before", aful, 0);
    afull_th = 5'd6;
    tick();
    chk("t6_aful_after", aful, 1);
    aempty_th = 5'd0;
    tick();
    chk("t6_aemp_cnt8", aemp, 0);
    for (int i = 0; i < 8; i++) begin
      re = 1'b1;
      tick();
      if (i == 6) chk("t6_aemp_cnt1", aemp, 0);
    end
    re = 1'b0;
    chk("t6_aemp_cnt0", aemp, 1);
    afull_th = 5'd0;
    tick();
    chk("t6_aful_th0", aful, 1);
    afull_th = 5'd17;
    tick();
    chk("t6_aful_th17", aful, 0);
    afull_th = 5'd14; aempty_th = 5'd2;
    tick();

    // 4: first-word-fall-through timing
    f_we = 1'b1; f_wd = 8'h5A;
    tick();
    f_we = 1'b0;
    chk("t4_emp_t1", f_emp, 1);
    tick();
    chk("t4_emp_t2", f_emp, 0);
    chk("t4_rd_t2", f_rd, 8'h5A);
    chk("t4_cnt_t2", f_cnt, 1);
    tick();
    f_re = 1'b1;
    tick();
    f_re = 1'b0;
    chk("t4_emp_t4", f_emp, 1);
    chk("t4_cnt_t4", f_cnt, 0);
    for (int i = 0; i < 3; i++) begin
      f_we = 1'b1; f_wd = 8'(8'h61 + i);
      tick();
    end
    f_we = 1'b0;
    tick();
    chk("t4_burst_w0", f_rd, 8'h61);
    f_re = 1'b1;
    tick();
    chk("t4_burst_w1", f_rd, 8'h62);
    tick();
    chk("t4_burst_w2", f_rd, 8'h63);
    tick();
    f_re = 1'b0;
    chk("t4_burst_emp", f_emp, 1);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/syncfifo_param.md
Name: syncfifo_param

Overview:
Parametrised synchronous FIFO, the next generation of the team's fixed 8-bit/4095-deep FIFO. Adds:
- configurable width and depth, with a full power-of-two capacity;
- runtime-programmable almost-full and almost-empty thresholds;
- optional first-word-fall-through (FWFT) read mode;
- a synchronous flush input;
- sticky overflow/underflow error flags.

It sits between crypto cores and host/UART/trace interfaces, in the same single clock domain.

Parameters:
WIDTH, 8, data width in bits.
AW, 12, address width; capacity = 2^AW entries.
FWFT, 0, 0 = standard read (data one cycle after pop); 1 = head word presented before pop.

Ports:
clk  in  1  clock; all logic on rising edge.
rst_n  in  1  reset, synchronous, active-low.
clr  in  1  synchronous flush, active-high.
wd  in  WIDTH  write data.
we  in  1  write request.
ful  out  1  full.
aful  out  1  almost full (cnt >= afull_th).
rd  out  WIDTH  read data.
re  in  1  read request / pop.
emp  out  1  empty (no word readable).
aemp  out  1  almost empty (cnt <= aempty_th).
afull_th  in  AW+1  almost-full threshold, sampled every cycle.
aempty_th  in  AW+1  almost-empty threshold, sampled every cycle.
cnt  out  AW+1  words held, 0..2^AW.
ovf  out  1  sticky: write attempted while ful.
udf  out  1  sticky: read attempted while emp.

Behaviour:
Reset and flush
- Reset (rst_n=0 at an edge): cnt=0, emp=1, aemp=1, ful=0, aful=0, ovf=0, udf=0, rd=0, pointers=0. Memory contents are not cleared.
- Reset asserted mid-operation discards all stored words; no write or read completes in that cycle.
- clr=1: same state as reset except ovf/udf, which are held. clr takes priority over we/re in the same cycle.
- rst_n has priority over clr.

Accept rules and pointers
- Write accepted: wa = we & ~ful. Read accepted: ra = re & ~emp. ful and emp are the registered outputs.
- Rejected writes never modify memory.
- Pointers are AW bits and wrap naturally from 2^AW-1 to 0.
- cnt: +1 on wa&~ra, -1 on ~wa&ra, unchanged on both or neither.
- Simultaneous we&re:
  - when full, only the read is accepted; cnt goes to 2^AW-1.
  - when empty, only the write is accepted; cnt goes to 1.
  - otherwise both are accepted and cnt is unchanged.

Flags
- All flags are registered and computed from next_cnt, so each is valid in the cycle after the causing edge.
- ful = (next_cnt == 2^AW).
- emp = (next_cnt == 0) in standard mode.
- aful = (next_cnt >= afull_th); aemp = (next_cnt <= aempty_th).
- Threshold changes take effect on the following edge.
- Threshold 0 keeps aful permanently 1. A threshold above 2^AW keeps aful permanently 0.
- ovf is set on we&ful; udf is set on re&emp. Both are cleared only by reset.

Standard mode (FWFT=0)
- rd is registered; it shows mem[read ptr] one cycle after the accepted read.
- rd holds its value until the next accepted read.

FWFT mode (FWFT=1)
- One output register with a valid bit. emp = ~valid.
- cnt includes the word held in the output register.
- Head word appears on rd 2 cycles after the first write into an empty FIFO: memory write, then prefetch.
- An accepted re loads the next word in the same edge, if memory holds one; otherwise valid clears.
- ful/aful/aemp/cnt semantics are unchanged.

Memory
- Simple dual-port, with a synchronous read suitable for block RAM.
- Write and read of the same address in one cycle is legal only when cnt>0; the read returns the old data, which is the oldest word.

Decomposition:
- Shared package/header syncfifo_pkg:
  - clog2 constant function;
  - default WIDTH/AW;
  - localparams DEPTH_N = 1<<AW and CNTW = AW+1.
- Sub-module syncfifo_ram: WIDTH×2^AW simple dual-port RAM, one write port, one registered read port, carrying the block-RAM synthesis attribute.
- syncfifo_param holds the pointers, count, flags and FWFT output stage.

Test Plan:
1. WIDTH=8, AW=4, FWFT=0, afull_th=14, aempty_th=2: write 0x00..0x0F → ful=1 the cycle after the 16th write, aful=1 after the 14th. A 17th write sets ovf=1 and cnt stays 16. Reading 16 words returns 0x00..0x0F in order, each one cycle after its re.
2. Empty FIFO, re=1 → udf=1, cnt=0, rd unchanged. Then we&re together at cnt=0 → only the write is accepted, cnt=1, emp=0 the next cycle.
3. cnt=16 (full), we&re with wd=0xAA → the read pops the oldest word, cnt=15, 0xAA is not stored, ovf unchanged. At cnt=5, continuous we&re for 40 cycles → cnt stays 5 and the pointers wrap.
4. FWFT=1: write 0x5A at cycle t into an empty FIFO → rd=0x5A and emp=0 at t+2 without re. re at t+3 → emp=1 at t+4. A burst of 3 writes then back-to-back re → 3 words on consecutive cycles.
5. cnt=9, clr pulse with we=1 → cnt=0, emp=1, aemp=1, ful=0, ovf/udf held, the write is discarded. Then rst_n=0 for 1 cycle with cnt=7 → all outputs at their reset values on the next edge.
6. Change afull_th from 14 to 6 while cnt=8 → aful rises on the next edge. Set aempty_th=0 → aemp=1 only when cnt=0.
